uart_receiver: RTL and testbench

UART_RECEIVER -- requirements
Module: uart_receiver

---
 rtl/uart_rx_if.sv | 25 ++
 rtl/uart_receiver.sv | 154 +++++++++++++++
 tb/tb_uart_receiver.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Serial-line and receive-result signals between a UART receiver and its user.
// The receiver drives the results; the line itself comes from the user side.
interface uart_rx_if;
  logic       uart_rx;
  logic [7:0] rx_data;
  logic       rx_status;
  logic       rx_busy;
  logic       frame_err;

  modport master (
    output uart_rx,
    input  rx_data,
    input  rx_status,
    input  rx_busy,
    input  frame_err
  );

  modport slave (
    input  uart_rx,
    output rx_data,
    output rx_status,
    output rx_busy,
    output frame_err
  );
endinterface

// File: rtl/uart_receiver.sv
// Oversampling 8N1 UART receiver: the line is synchronized, the start bit is qualified at
// mid-bit, and data/stop bits are sampled once per bit period.
module uart_receiver #(
  parameter int unsigned OS_RATE = 16
) (
  input  logic      quick_clk,
  input  logic      reset,
  uart_rx_if.slave  bus
);

  localparam int unsigned CNT_W = (OS_RATE > 2) ? $clog2(OS_RATE) : 1;
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(OS_RATE / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(OS_RATE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  logic             r_rx_meta;
  logic             r_rx_s;
  logic [1:0]       r_warm;
  logic             r_armed;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_idx;
  logic [7:0]       r_shift;
  logic [7:0]       r_rx_data;
  logic             r_rx_status;
  logic             r_frame_err;
  logic             r_busy;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [2:0]       w_idx_nxt;
  logic [7:0]       w_shift_nxt;
  logic [7:0]       w_data_nxt;
  logic             w_status_nxt;
  logic             w_ferr_nxt;
  logic             w_armed_nxt;
  logic             w_busy_nxt;

  // A start is only accepted once the synchronized line has been seen high after the last
  // frame (or after reset, once the synchronizer holds real line samples), so a break or a
  // line still low when reset is released never looks like a fresh falling edge.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_idx_nxt    = r_idx;
    w_shift_nxt  = r_shift;
    w_data_nxt   = r_rx_data;
    w_status_nxt = 1'b0;
    w_ferr_nxt   = 1'b0;
    w_armed_nxt  = r_armed | (r_warm[1] & r_rx_s);

    unique case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (!r_rx_s && r_armed) begin
          w_state_nxt = START;
        end
      end

      START: begin
        if (r_cnt == HALF_M1) begin
          w_cnt_nxt = '0;
          if (!r_rx_s) begin
            w_state_nxt = DATA;
            w_idx_nxt   = 3'd0;
          end else begin
            w_state_nxt = IDLE;
          end
        end else begin
          w_cnt_nxt = CNT_W'(r_cnt + 1'b1);
        end
      end

      DATA: begin
        if (r_cnt == FULL_M1) begin
          w_cnt_nxt           = '0;
          w_shift_nxt[r_idx]  = r_rx_s;
          w_idx_nxt           = 3'(r_idx + 3'd1);
          if (r_idx == 3'd7) begin
            w_state_nxt = STOP;
          end
        end else begin
          w_cnt_nxt = CNT_W'(r_cnt + 1'b1);
        end
      end

      STOP: begin
        if (r_cnt == FULL_M1) begin
          w_cnt_nxt   = '0;
          w_state_nxt = IDLE;
          w_armed_nxt = 1'b0;
          if (r_rx_s) begin
            w_data_nxt   = r_shift;
            w_status_nxt = 1'b1;
          end else begin
            w_ferr_nxt = 1'b1;
          end
        end else begin
          w_cnt_nxt = CNT_W'(r_cnt + 1'b1);
        end
      end

      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase

    w_busy_nxt = (w_state_nxt != IDLE);
  end

  // State, datapath and output registers; synchronizer resets to the idle-high level.
  always_ff @(posedge quick_clk) begin
    if (!reset) begin
      r_rx_meta   <= 1'b1;
      r_rx_s      <= 1'b1;
      r_warm      <= 2'b00;
      r_armed     <= 1'b0;
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_idx       <= 3'd0;
      r_shift     <= 8'h00;
      r_rx_data   <= 8'h00;
      r_rx_status <= 1'b0;
      r_frame_err <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_rx_meta   <= bus.uart_rx;
      r_rx_s      <= r_rx_meta;
      r_warm      <= {r_warm[0], 1'b1};
      r_armed     <= w_armed_nxt;
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_idx       <= w_idx_nxt;
      r_shift     <= w_shift_nxt;
      r_rx_data   <= w_data_nxt;
      r_rx_status <= w_status_nxt;
      r_frame_err <= w_ferr_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  assign bus.rx_data   = r_rx_data;
  assign bus.rx_status = r_rx_status;
  assign bus.rx_busy   = r_busy;
  assign bus.frame_err = r_frame_err;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: a 16x instance driven from a frame table plus corner
// sequences (glitch, break, mid-frame reset), and an 8x instance for the alternate rate.
module tb_uart_receiver;

  localparam int OS  = 16;
  localparam int OS8 = 8;

  logic quick_clk = 1'b0;
  logic reset     = 1'b0;

  uart_rx_if bus16 ();
  uart_rx_if bus8 ();

  uart_receiver #(.OS_RATE(OS)) dut16 (
    .quick_clk (quick_clk),
    .reset     (reset),
    .bus       (bus16)
  );

  uart_receiver #(.OS_RATE(OS8)) dut8 (
    .quick_clk (quick_clk),
    .reset     (reset),
    .bus       (bus8)
  );

  always #5 quick_clk = ~quick_clk;

  int cyc = 0;
  always @(posedge quick_clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         cyc;
    bit         ferr;
    logic [7:0] data;
  } evt_t;

  evt_t evq[$];
  evt_t ev8q[$];
  int   bfq[$];
  int   excl_bad = 0;
  logic busy_q   = 1'b0;
  evt_t mon_e;
  evt_t mon8_e;

  // Log every result pulse and every busy falling edge of the 16x instance.
  always @(negedge quick_clk) begin
    if (bus16.rx_status === 1'b1 || bus16.frame_err === 1'b1) begin
      mon_e.cyc  = cyc;
      mon_e.ferr = bus16.frame_err;
      mon_e.data = bus16.rx_data;
      evq.push_back(mon_e);
      if (bus16.rx_status === 1'b1 && bus16.frame_err === 1'b1) excl_bad = excl_bad + 1;
    end
    if (busy_q === 1'b1 && bus16.rx_busy === 1'b0) bfq.push_back(cyc);
    busy_q <= bus16.rx_busy;
  end

  always @(negedge quick_clk) begin
    if (bus8.rx_status === 1'b1 || bus8.frame_err === 1'b1) begin
      mon8_e.cyc  = cyc;
      mon8_e.ferr = bus8.frame_err;
      mon8_e.data = bus8.rx_data;
      ev8q.push_back(mon8_e);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Drives one frame starting at the current negedge; returns the cycle the start bit began.
  task automatic send(input bit sel8, input logic [7:0] d, input logic stopb, output int t0);
    int os;
    os = sel8 ? OS8 : OS;
    t0 = cyc;
    if (sel8) bus8.uart_rx = 1'b0; else bus16.uart_rx = 1'b0;
    repeat (os) @(negedge quick_clk);
    for (int i = 0; i < 8; i++) begin
      if (sel8) bus8.uart_rx = d[i]; else bus16.uart_rx = d[i];
      repeat (os) @(negedge quick_clk);
    end
    if (sel8) bus8.uart_rx = stopb; else bus16.uart_rx = stopb;
    repeat (os) @(negedge quick_clk);
    if (sel8) bus8.uart_rx = 1'b1; else bus16.uart_rx = 1'b1;
  endtask

  typedef struct {
    logic [7:0] d;
    logic       stopb;
    int         tail_low;
    int         gap;
    bit         exp_ferr;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[6];
  int   t0s[6];
  int   tg, tf, tr, t5a, t8, n;
  int   lat16, lat8;

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 0,   20, 1'b0, 8'hA5};
    vecs[1] = '{8'h00, 1'b1, 0,   0,  1'b0, 8'h00};
    vecs[2] = '{8'hFF, 1'b1, 0,   20, 1'b0, 8'hFF};
    vecs[3] = '{8'h3C, 1'b0, 0,   40, 1'b1, 8'hFF};
    vecs[4] = '{8'h00, 1'b0, 100, 40, 1'b1, 8'hFF};
    vecs[5] = '{8'h12, 1'b1, 0,   20, 1'b0, 8'h12};
    lat16 = 3 + OS / 2 + 9 * OS;
    lat8  = 3 + OS8 / 2 + 9 * OS8;

    bus16.uart_rx = 1'b1;
    bus8.uart_rx  = 1'b1;
    reset         = 1'b0;
    repeat (5) @(negedge quick_clk);
    chk("reset_rx_data",   int'(bus16.rx_data),   0);
    chk("reset_rx_status", int'(bus16.rx_status), 0);
    chk("reset_frame_err", int'(bus16.frame_err), 0);
    chk("reset_rx_busy",   int'(bus16.rx_busy),   0);
    reset = 1'b1;
    repeat (20) @(negedge quick_clk);

    // 4-cycle low glitch: false start rejected at mid-bit, no pulses
    tg = cyc;
    bus16.uart_rx = 1'b0;
    repeat (4) @(negedge quick_clk);
    bus16.uart_rx = 1'b1;
    repeat (40) @(negedge quick_clk);
    chk("glitch_pulses", evq.size(), 0);
    chk("glitch_busy_falls", bfq.size(), 1);
    if (bfq.size() > 0) chk("glitch_idle_cycle", bfq[0] - tg, 11);
    evq.delete();
    bfq.delete();

    // Frame table, including back-to-back frames and a framing error followed by a break
    for (int i = 0; i < 6; i++) begin
      send(1'b0, vecs[i].d, vecs[i].stopb, t0s[i]);
      if (vecs[i].tail_low > 0) begin
        bus16.uart_rx = 1'b0;
        repeat (vecs[i].tail_low) @(negedge quick_clk);
        bus16.uart_rx = 1'b1;
      end
      repeat (vecs[i].gap) @(negedge quick_clk);
    end
    chk("table_event_count", evq.size(), 6);
    chk("table_busy_falls", bfq.size(), 6);
    n = (evq.size() < 6) ? evq.size() : 6;
    for (int i = 0; i < n; i++) begin
      chk($sformatf("vec%0d_pulse_cycle", i), evq[i].cyc - t0s[i], lat16);
      chk($sformatf("vec%0d_is_ferr", i), int'(evq[i].ferr), int'(vecs[i].exp_ferr));
      chk($sformatf("vec%0d_rx_data", i), int'(evq[i].data), int'(vecs[i].exp_data));
    end
    n = (bfq.size() < 6) ? bfq.size() : 6;
    for (int i = 0; i < n; i++) begin
      chk($sformatf("vec%0d_busy_fall", i), bfq[i] - t0s[i], lat16);
    end
    if (evq.size() >= 3) chk("b2b_spacing", evq[2].cyc - evq[1].cyc, 160);
    evq.delete();
    bfq.delete();

    // Reset during data bit 4 of 0xC3, then a clean 0x5A
    tf = cyc;
    fork
      send(1'b0, 8'hC3, 1'b1, tr);
      begin
        repeat (88) @(negedge quick_clk);
        reset = 1'b0;
        repeat (3) @(negedge quick_clk);
        reset = 1'b1;
      end
    join
    repeat (20) @(negedge quick_clk);
    chk("abort_no_pulse", evq.size(), 0);
    chk("abort_rx_data", int'(bus16.rx_data), 0);
    chk("abort_busy_falls", bfq.size(), 1);
    if (bfq.size() > 0) chk("abort_busy_cycle", bfq[0] - tf, 89);
    chk("abort_frame_start", tr, tf);
    send(1'b0, 8'h5A, 1'b1, t5a);
    repeat (20) @(negedge quick_clk);
    chk("after_abort_events", evq.size(), 1);
    if (evq.size() > 0) begin
      chk("after_abort_cycle", evq[0].cyc - t5a, lat16);
      chk("after_abort_data", int'(evq[0].data), 8'h5A);
      chk("after_abort_ferr", int'(evq[0].ferr), 0);
    end
    chk("final_rx_data16", int'(bus16.rx_data), 8'h5A);
    chk("final_busy16", int'(bus16.rx_busy), 0);

    // Alternate oversampling rate
    send(1'b1, 8'h81, 1'b1, t8);
    repeat (20) @(negedge quick_clk);
    chk("os8_events", ev8q.size(), 1);
    if (ev8q.size() > 0) begin
      chk("os8_pulse_cycle", ev8q[0].cyc - t8, lat8);
      chk("os8_data", int'(ev8q[0].data), 8'h81);
      chk("os8_ferr", int'(ev8q[0].ferr), 0);
    end
    chk("os8_busy", int'(bus8.rx_busy), 0);

    chk("status_ferr_exclusive", excl_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
